// File: rtl/clk_seq_pkg.sv
// Shared types and helpers for the clock-enable sequencer.
// Holds the sequencer state encoding and the counter sizing function.
package clk_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_STARTUP,
        ST_IDLE,
        ST_ENABLE,
        ST_FAULT
    } seq_state_t;

    // Smallest width (at least 1) that can hold the value max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/refclk_activity_mon.sv
// Reference clock activity monitor: synchronises the divided refclk,
// counts its rising edges per window and reports whether enough arrived.
module refclk_activity_mon #(
    parameter int WIN_CYCLES = 1024,
    parameter int MIN_EDGES  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic refclk_div_in,
    output logic refclk_ok
);
    import clk_seq_pkg::*;

    localparam int EW = cnt_width(MIN_EDGES);
    localparam int WW = cnt_width(WIN_CYCLES);
    localparam logic [EW-1:0] EDGE_MAX = EW'(MIN_EDGES);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYCLES - 1);

    // Bits [1:0] form the two-flop synchroniser; bit 2 is the edge-detect history.
    logic [2:0]    sync_q;
    logic          rise;
    logic [EW-1:0] edge_cnt;
    logic [WW-1:0] win_cnt;

    assign rise = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            edge_cnt  <= '0;
            win_cnt   <= '0;
            refclk_ok <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], refclk_div_in};
            if (win_cnt == WIN_LAST) begin
                win_cnt   <= '0;
                edge_cnt  <= '0;
                refclk_ok <= (edge_cnt >= EDGE_MAX);
            end else begin
                win_cnt <= win_cnt + WW'(1);
                if (rise && (edge_cnt != EDGE_MAX)) begin
                    edge_cnt <= edge_cnt + EW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/clk_ce_sequencer.sv
// Staggered clock-enable sequencer: brings up per-channel BUFHCE enables one at a
// time once the reference clock is proven active, with a reset hold per channel.
module clk_ce_sequencer #(
    parameter int NUM_CH          = 4,
    parameter int STARTUP_CYCLES  = 256,
    parameter int STAGGER_CYCLES  = 16,
    parameter int RST_HOLD_CYCLES = 8,
    parameter int WIN_CYCLES      = 1024,
    parameter int MIN_EDGES       = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              refclk_div_in,
    input  logic [NUM_CH-1:0] ch_req,
    output logic [NUM_CH-1:0] ch_ce,
    output logic [NUM_CH-1:0] ch_rst,
    output logic [NUM_CH-1:0] ch_ack,
    output logic              refclk_ok,
    output logic              seq_busy
);
    import clk_seq_pkg::*;

    localparam int SW  = cnt_width(STARTUP_CYCLES);
    localparam int STW = cnt_width(STAGGER_CYCLES);
    localparam int HW  = cnt_width(RST_HOLD_CYCLES);
    localparam logic [SW-1:0]  STARTUP_LAST = SW'(STARTUP_CYCLES - 1);
    // The IDLE decision cycle completes the interval, so ENABLE lasts one cycle less.
    localparam logic [STW-1:0] STAGGER_LAST = STW'((STAGGER_CYCLES > 1) ? STAGGER_CYCLES - 2 : 0);
    localparam logic [HW-1:0]  HOLD_LAST    = HW'((RST_HOLD_CYCLES > 0) ? RST_HOLD_CYCLES - 1 : 0);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [SW-1:0]     startup_cnt;
    logic [STW-1:0]    stagger_cnt;
    logic [HW-1:0]     hold_cnt [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] ce_set;
    logic              kill_all;

    refclk_activity_mon #(
        .WIN_CYCLES(WIN_CYCLES),
        .MIN_EDGES (MIN_EDGES)
    ) u_mon (
        .clk          (sys_clk),
        .rst          (sys_rst),
        .refclk_div_in(refclk_div_in),
        .refclk_ok    (refclk_ok)
    );

    assign pending  = ch_req & ~ch_ce;
    assign sel      = pending & (~pending + NUM_CH'(1));
    assign seq_busy = (state != ST_IDLE);
    assign ch_ack   = ch_ce & ~ch_rst;

    always_comb begin
        state_next = state;
        ce_set     = '0;
        kill_all   = 1'b0;
        case (state)
            ST_RESET: state_next = ST_STARTUP;
            ST_STARTUP: begin
                if (refclk_ok && (startup_cnt == STARTUP_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Fault wins over a simultaneous enable.
                if (!refclk_ok) begin
                    kill_all   = 1'b1;
                    state_next = ST_FAULT;
                end else if (|pending) begin
                    ce_set     = sel;
                    state_next = ST_ENABLE;
                end
            end
            ST_ENABLE: begin
                if (!refclk_ok) begin
                    kill_all   = 1'b1;
                    state_next = ST_FAULT;
                end else if (stagger_cnt == STAGGER_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (refclk_ok) begin
                    state_next = ST_STARTUP;
                end
            end
            default: state_next = ST_RESET;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= ST_RESET;
            startup_cnt <= '0;
            stagger_cnt <= '0;
        end else begin
            state <= state_next;
            if ((state == ST_STARTUP) && refclk_ok) begin
                startup_cnt <= startup_cnt + SW'(1);
            end else begin
                startup_cnt <= '0;
            end
            if (state == ST_ENABLE) begin
                stagger_cnt <= stagger_cnt + STW'(1);
            end else begin
                stagger_cnt <= '0;
            end
        end
    end

    // Per-channel CE and reset hold; a dropped request aborts any hold in progress.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ch_ce  <= '0;
            ch_rst <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (kill_all || !ch_req[i]) begin
                    ch_ce[i]    <= 1'b0;
                    ch_rst[i]   <= 1'b1;
                    hold_cnt[i] <= '0;
                end else if (ce_set[i]) begin
                    ch_ce[i]    <= 1'b1;
                    ch_rst[i]   <= (RST_HOLD_CYCLES != 0);
                    hold_cnt[i] <= '0;
                end else if (ch_ce[i] && ch_rst[i]) begin
                    if (hold_cnt[i] == HOLD_LAST) begin
                        ch_rst[i] <= 1'b0;
                    end else begin
                        hold_cnt[i] <= hold_cnt[i] + HW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_ce_sequencer.sv
// Scoreboard bench for clk_ce_sequencer: stimulus queues expected output changes,
// a negedge monitor pops and checks each change including its cycle spacing.
module tb_clk_ce_sequencer;
    import clk_seq_pkg::*;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       refclk_div_in = 1'b0;
    logic [3:0] ch_req;
    logic [3:0] ch_ce;
    logic [3:0] ch_rst;
    logic [3:0] ch_ack;
    logic       refclk_ok;
    logic       seq_busy;

    typedef struct {
        logic       ok;
        logic [3:0] ce;
        logic [3:0] ack;
        int         gap;
        int         id;
    } exp_t;

    exp_t       exp_q[$];
    int         next_id      = 0;
    int         tests_run    = 0;
    int         tests_failed = 0;
    int         cyc          = 0;
    int         ref_cyc      = 0;
    int         ref_mode     = 1;
    bit         mon_en       = 1'b0;
    bit         mon_init     = 1'b0;
    logic [8:0] prev_obs;

    clk_ce_sequencer #(
        .NUM_CH         (4),
        .STARTUP_CYCLES (256),
        .STAGGER_CYCLES (16),
        .RST_HOLD_CYCLES(8),
        .WIN_CYCLES     (1024),
        .MIN_EDGES      (4)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .refclk_div_in(refclk_div_in),
        .ch_req       (ch_req),
        .ch_ce        (ch_ce),
        .ch_rst       (ch_rst),
        .ch_ack       (ch_ack),
        .refclk_ok    (refclk_ok),
        .seq_busy     (seq_busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Mode 1: fast free-running refclk; 2: one rising edge per 350 sys cycles; 0: stopped.
    initial begin
        forever begin
            if (ref_mode == 1) begin
                #17 refclk_div_in = ~refclk_div_in;
            end else if (ref_mode == 2) begin
                #1750 refclk_div_in = ~refclk_div_in;
            end else begin
                refclk_div_in = 1'b0;
                #10;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    always @(negedge sys_clk) begin
        logic [8:0] obs;
        exp_t       e;
        obs = {refclk_ok, ch_ce, ch_ack};
        if (mon_en) begin
            if (!mon_init) begin
                prev_obs = obs;
                mon_init = 1'b1;
            end else if (obs !== prev_obs) begin
                prev_obs = obs;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL unexpected_event: got ok=%b ce=%b ack=%b at cycle %0d, required no change",
                             obs[8], obs[7:4], obs[3:0], cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({e.ok, e.ce, e.ack} !== obs) begin
                        tests_failed++;
                        $display("[TB] FAIL event%0d: got ok=%b ce=%b ack=%b, required ok=%b ce=%b ack=%b",
                                 e.id, obs[8], obs[7:4], obs[3:0], e.ok, e.ce, e.ack);
                    end
                    if (e.gap >= 0) begin
                        tests_run++;
                        if ((cyc - ref_cyc) != e.gap) begin
                            tests_failed++;
                            $display("[TB] FAIL event%0d_gap: got %0d cycles, required %0d",
                                     e.id, cyc - ref_cyc, e.gap);
                        end
                    end
                end
                ref_cyc = cyc;
            end
        end
    end

    task automatic pushExp(input logic ok, input logic [3:0] ce, input logic [3:0] ack, input int gap);
        exp_t e;
        e.ok  = ok;
        e.ce  = ce;
        e.ack = ack;
        e.gap = gap;
        e.id  = next_id;
        next_id++;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] req);
        @(negedge sys_clk);
        ch_req  = req;
        ref_cyc = cyc;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic waitDrain(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge sys_clk);
            n++;
        end
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain_%s: got %0d pending events, required 0", tag, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        sys_rst = 1'b1;
        ch_req  = 4'b0001;
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_ce",    32'(ch_ce),     32'h0);
        checkOutput("rst_ack",   32'(ch_ack),    32'h0);
        checkOutput("rst_rst",   32'(ch_rst),    32'hF);
        checkOutput("rst_ok",    32'(refclk_ok), 32'h0);
        checkOutput("rst_busy",  32'(seq_busy),  32'h1);
        checkOutput("rst_state", 32'(dut.state), 32'(ST_RESET));
        mon_en = 1'b1;
        @(negedge sys_clk);

        // Bring-up of a single channel.
        pushExp(1'b1, 4'b0000, 4'b0000, 1024);
        pushExp(1'b1, 4'b0001, 4'b0000, 257);
        pushExp(1'b1, 4'b0001, 4'b0001, 8);
        sys_rst = 1'b0;
        ref_cyc = cyc;
        waitDrain(1400, "bringup");
        repeat (20) @(negedge sys_clk);
        checkOutput("bringup_rst",  32'(ch_rst),   32'hE);
        checkOutput("bringup_busy", 32'(seq_busy), 32'h0);

        // Simultaneous requests come up lowest index first, 16 cycles apart.
        pushExp(1'b0, 4'b0000, 4'b0000, -1);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        ch_req  = 4'b1011;
        repeat (3) @(negedge sys_clk);
        waitDrain(5, "reset2");
        pushExp(1'b1, 4'b0000, 4'b0000, 1024);
        pushExp(1'b1, 4'b0001, 4'b0000, 257);
        pushExp(1'b1, 4'b0001, 4'b0001, 8);
        pushExp(1'b1, 4'b0011, 4'b0001, 8);
        pushExp(1'b1, 4'b0011, 4'b0011, 8);
        pushExp(1'b1, 4'b1011, 4'b0011, 8);
        pushExp(1'b1, 4'b1011, 4'b1011, 8);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        ref_cyc = cyc;
        waitDrain(1500, "stagger");
        repeat (20) @(negedge sys_clk);

        // Request drop during the reset hold.
        pushExp(1'b1, 4'b1001, 4'b1001, 1);
        applyStimulus(4'b1001);
        waitDrain(5, "drop_idle");
        repeat (2) @(negedge sys_clk);
        pushExp(1'b1, 4'b1011, 4'b1001, 1);
        applyStimulus(4'b1011);
        waitDrain(5, "reenable1");
        @(negedge sys_clk);
        pushExp(1'b1, 4'b1001, 4'b1001, 1);
        applyStimulus(4'b1001);
        waitDrain(5, "drop_hold");
        checkOutput("drop_rst", 32'(ch_rst), 32'h6);
        checkOutput("drop_ce1", 32'(ch_ce[1]), 32'h0);
        repeat (30) @(negedge sys_clk);
        checkOutput("drop_no_ack1", 32'(ch_ack[1]), 32'h0);

        // Refclk loss with channels up, then recovery.
        pushExp(1'b1, 4'b1011, 4'b1001, 1);
        pushExp(1'b1, 4'b1011, 4'b1011, 8);
        applyStimulus(4'b1011);
        waitDrain(20, "ch1_back");
        pushExp(1'b0, 4'b1011, 4'b1011, -1);
        pushExp(1'b0, 4'b0000, 4'b0000, 1);
        ref_mode = 0;
        waitDrain(2500, "refclk_loss");
        checkOutput("loss_state", 32'(dut.state), 32'(ST_FAULT));
        checkOutput("loss_rst",   32'(ch_rst),    32'hF);
        checkOutput("loss_busy",  32'(seq_busy),  32'h1);
        pushExp(1'b1, 4'b0000, 4'b0000, -1);
        pushExp(1'b1, 4'b0001, 4'b0000, 258);
        pushExp(1'b1, 4'b0001, 4'b0001, 8);
        pushExp(1'b1, 4'b0011, 4'b0001, 8);
        pushExp(1'b1, 4'b0011, 4'b0011, 8);
        pushExp(1'b1, 4'b1011, 4'b0011, 8);
        pushExp(1'b1, 4'b1011, 4'b1011, 8);
        ref_mode = 1;
        waitDrain(3000, "restart");
        repeat (20) @(negedge sys_clk);

        // Asynchronous reset while in ENABLE.
        pushExp(1'b1, 4'b1111, 4'b1011, 1);
        applyStimulus(4'b1111);
        waitDrain(5, "ch2_on");
        repeat (2) @(negedge sys_clk);
        checkOutput("pre_rst_state", 32'(dut.state), 32'(ST_ENABLE));
        pushExp(1'b0, 4'b0000, 4'b0000, -1);
        #2 sys_rst = 1'b1;
        #1;
        checkOutput("async_ce",    32'(ch_ce),     32'h0);
        checkOutput("async_ack",   32'(ch_ack),    32'h0);
        checkOutput("async_rst",   32'(ch_rst),    32'hF);
        checkOutput("async_ok",    32'(refclk_ok), 32'h0);
        checkOutput("async_busy",  32'(seq_busy),  32'h1);
        checkOutput("async_state", 32'(dut.state), 32'(ST_RESET));
        waitDrain(5, "async_reset");

        // Marginal refclk: at most 3 edges per window never qualifies.
        ref_mode = 2;
        repeat (10) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (4200) @(negedge sys_clk);
        checkOutput("marginal_ok",   32'(refclk_ok), 32'h0);
        checkOutput("marginal_ce",   32'(ch_ce),     32'h0);
        checkOutput("marginal_busy", 32'(seq_busy),  32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
